// File: rtl/div_sign_ctrl_pkg.sv
// Shared processor package: divide op encoding, control FSM states, divider
// function codes and small sign helpers.
package div_sign_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_FIX   = 3'd4,
    ST_DONE  = 3'd5
  } div_state_e;

  typedef enum logic {
    UFN_IDLE = 1'b0,
    UFN_DIV  = 1'b1
  } udiv_fn_e;

  // Operands captured when a request is accepted
  typedef struct packed {
    div_op_e         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } div_req_t;

  // Two's complement negation, wraps modulo 2^XLEN
  function automatic logic [XLEN-1:0] neg_xlen(input logic [XLEN-1:0] x);
    return XLEN'((~x) + XLEN'(1));
  endfunction

  // Magnitude of a signed value; abs(most negative) stays most negative
  function automatic logic [XLEN-1:0] abs_xlen(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? neg_xlen(x) : x;
  endfunction

  function automatic logic is_signed_op(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_ctrl_udiv.sv
// Unsigned restoring divider, one quotient bit per cycle. A start with the
// divide function code (re)loads the operands even if a previous divide is
// still in flight, so an aborted operation never blocks the next one.
module div_sign_ctrl_udiv
  import div_sign_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  udiv_fn_e        i_func,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem,
  output logic            o_busy
);

  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_diff;
  logic             w_fits;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    w_shift = {r_rem, r_quot[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_div};
    w_fits  = ~w_diff[XLEN];
  end

  // Operand load and iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start && (i_func == UFN_DIV)) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= CNT_W'(XLEN);
      r_busy <= 1'b1;
    end else if (r_cnt != '0) begin
      r_rem  <= w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quot <= {r_quot[XLEN-2:0], w_fits};
      r_cnt  <= r_cnt - CNT_W'(1);
      r_busy <= (r_cnt != CNT_W'(1));
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem;
  assign o_busy = r_busy;

endmodule

// File: rtl/div_sign_ctrl.sv
// Signed/unsigned divide controller: special-case resolution, magnitude
// formation and result sign fix-up around an unsigned iterative divider.
module div_sign_ctrl
  import div_sign_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            valid,
  output logic            busy
);

  div_state_e      r_state;
  div_state_e      w_next;
  div_req_t        r_req;
  logic [XLEN-1:0] r_mag_a;
  logic [XLEN-1:0] r_mag_b;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;
  logic            r_valid;
  logic            r_busy;

  logic            w_latch;
  logic            w_load_mag;
  logic            w_wr_special;
  logic            w_wr_fix;
  logic            w_div_start;
  udiv_fn_e        w_div_fn;

  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_val;
  logic [XLEN-1:0] w_fix_val;

  logic [XLEN-1:0] w_div_quot;
  logic [XLEN-1:0] w_div_rem;
  logic            w_div_busy;

  // Divide-by-zero and signed overflow detection on the latched request
  always_comb begin
    w_b_zero  = (r_req.b == '0);
    w_ovf     = is_signed_op(r_req.op) &&
                (r_req.a == {1'b1, {(XLEN-1){1'b0}}}) &&
                (r_req.b == '1);
    w_special = w_b_zero || w_ovf;
    if (w_b_zero) begin
      w_special_val = is_rem_op(r_req.op) ? r_req.a : '1;
    end else begin
      w_special_val = is_rem_op(r_req.op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Select quotient or remainder and restore its sign
  always_comb begin
    w_fix_val = w_div_quot;
    case (r_req.op)
      OP_DIV:  w_fix_val = r_neg_q ? neg_xlen(w_div_quot) : w_div_quot;
      OP_DIVU: w_fix_val = w_div_quot;
      OP_REM:  w_fix_val = r_neg_r ? neg_xlen(w_div_rem) : w_div_rem;
      OP_REMU: w_fix_val = w_div_rem;
      default: w_fix_val = w_div_quot;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control strobes; flush overrides every transition
  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_load_mag   = 1'b0;
    w_wr_special = 1'b0;
    w_wr_fix     = 1'b0;
    w_div_start  = 1'b0;
    w_div_fn     = UFN_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_latch = 1'b1;
          w_next  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_special) begin
          w_wr_special = 1'b1;
          w_next       = ST_DONE;
        end else begin
          w_load_mag = 1'b1;
          w_next     = ST_ARM;
        end
      end
      ST_ARM: begin
        w_div_fn    = UFN_DIV;
        w_div_start = 1'b1;
        w_next      = ST_RUN;
      end
      ST_RUN: begin
        w_div_fn = UFN_DIV;
        if (!w_div_busy) begin
          w_next = ST_FIX;
        end
      end
      ST_FIX: begin
        w_div_fn = UFN_DIV;
        w_wr_fix = 1'b1;
        w_next   = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (flush) begin
      w_next       = ST_IDLE;
      w_latch      = 1'b0;
      w_load_mag   = 1'b0;
      w_wr_special = 1'b0;
      w_wr_fix     = 1'b0;
      w_div_start  = 1'b0;
    end
  end

  // Capture the request when accepted in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= '0;
    end else if (w_latch) begin
      r_req <= '{op: div_op_e'(op), a: opa, b: opb};
    end
  end

  // Magnitudes and result sign flags, held from ARM through FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_load_mag) begin
      r_mag_a <= is_signed_op(r_req.op) ? abs_xlen(r_req.a) : r_req.a;
      r_mag_b <= is_signed_op(r_req.op) ? abs_xlen(r_req.b) : r_req.b;
      r_neg_q <= is_signed_op(r_req.op) && (r_req.a[XLEN-1] ^ r_req.b[XLEN-1]);
      r_neg_r <= is_signed_op(r_req.op) && r_req.a[XLEN-1];
    end
  end

  // Result register, written only by a special case or the FIX step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_wr_special) begin
      r_result <= w_special_val;
    end else if (w_wr_fix) begin
      r_result <= w_fix_val;
    end
  end

  // Registered handshake outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= (w_next == ST_DONE);
      r_busy  <= (w_next == ST_CHECK) || (w_next == ST_ARM) ||
                 (w_next == ST_RUN)   || (w_next == ST_FIX);
    end
  end

  div_sign_ctrl_udiv u_udiv (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_func     (w_div_fn),
    .i_dividend (r_mag_a),
    .i_divisor  (r_mag_b),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem),
    .o_busy     (w_div_busy)
  );

  assign result = r_result;
  assign valid  = r_valid;
  assign busy   = r_busy;

endmodule
